// File: rtl/pattern_sequencer.sv
// N-channel step sequencer: writable channel x step pattern RAM, IDLE/PLAY/PAUSE step engine
// and a free-running note_clk square wave for the channel FX blocks.
module pattern_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int STEPS          = 16,
  parameter int NOTE_W         = 6,
  parameter int STEP_TICKS     = 6000000,
  parameter int NOTE_CLK_TICKS = 390625,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int STEP_W        = $clog2(STEPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     restart,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [STEP_W-1:0]        wr_step,
  input  logic [NOTE_W-1:0]        wr_note,
  input  logic                     wr_gate,
  output logic [NUM_CH*NOTE_W-1:0] note_out,
  output logic [NUM_CH-1:0]        gate_out,
  output logic [STEP_W-1:0]        step_idx,
  output logic                     step_pulse,
  output logic                     note_clk,
  output logic                     beat_led
);

  localparam int TICK_W = $clog2(STEP_TICKS);
  localparam int NCLK_W = (NOTE_CLK_TICKS > 1) ? $clog2(NOTE_CLK_TICKS) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(STEP_TICKS - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [NCLK_W-1:0] LAST_NCLK = NCLK_W'(NOTE_CLK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  state_t state, state_nxt;

  // Each entry is {gate, note}; kept in flops because reset must clear the whole pattern.
  logic [NOTE_W:0] ram [NUM_CH][STEPS];

  logic [TICK_W-1:0]        tick, tick_nxt;
  logic [STEP_W-1:0]        step_nxt;
  logic [NUM_CH*NOTE_W-1:0] note_nxt;
  logic [NUM_CH-1:0]        gate_nxt;
  logic                     pulse_nxt;
  logic                     beat_nxt;
  logic                     load;
  logic [STEP_W-1:0]        load_step;
  logic [NOTE_W:0]          entry;
  logic                     wr_ok;
  logic [NCLK_W-1:0]        nclk_cnt;

  assign wr_ok = wr_en && (32'(wr_ch) < NUM_CH) && (32'(wr_step) < STEPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < STEPS; s++) begin
          ram[c][s] <= '0;
        end
      end
    end else if (wr_ok) begin
      ram[wr_ch][wr_step] <= {wr_gate, wr_note};
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    step_nxt  = step_idx;
    note_nxt  = note_out;
    gate_nxt  = gate_out;
    pulse_nxt = 1'b0;
    beat_nxt  = beat_led;
    load      = 1'b0;
    load_step = step_idx;
    entry     = '0;

    if (restart) begin
      state_nxt = IDLE;
      tick_nxt  = '0;
      step_nxt  = '0;
      gate_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state_nxt = PLAY;
            tick_nxt  = '0;
            load      = 1'b1;
            load_step = '0;
          end
        end
        // Resuming from PAUSE counts on the same edge, so a pause of N clocks delays the step by N.
        PLAY, PAUSE: begin
          if (!run) begin
            state_nxt = PAUSE;
          end else begin
            state_nxt = PLAY;
            if (tick == LAST_TICK) begin
              tick_nxt  = '0;
              load      = 1'b1;
              load_step = (step_idx == LAST_STEP) ? '0 : step_idx + 1'b1;
            end else begin
              tick_nxt = tick + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // A silent step keeps the previous note so pitch FX do not glide down to note 0.
    if (load) begin
      step_nxt  = load_step;
      pulse_nxt = 1'b1;
      beat_nxt  = ~beat_led;
      for (int k = 0; k < NUM_CH; k++) begin
        entry       = ram[k][load_step];
        gate_nxt[k] = entry[NOTE_W];
        if (entry[NOTE_W]) begin
          note_nxt[k*NOTE_W +: NOTE_W] = entry[NOTE_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick       <= '0;
      step_idx   <= '0;
      note_out   <= '0;
      gate_out   <= '0;
      step_pulse <= 1'b0;
      beat_led   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick       <= tick_nxt;
      step_idx   <= step_nxt;
      note_out   <= note_nxt;
      gate_out   <= gate_nxt;
      step_pulse <= pulse_nxt;
      beat_led   <= beat_nxt;
    end
  end

  // note_clk ignores run/restart entirely so channel FX keep a steady time base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nclk_cnt <= '0;
      note_clk <= 1'b0;
    end else if (nclk_cnt == LAST_NCLK) begin
      nclk_cnt <= '0;
      note_clk <= ~note_clk;
    end else begin
      nclk_cnt <= nclk_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: directed scenarios plus randomized run/restart/write
// traffic compared each cycle against a behavioural model of the sequencer.
module tb_pattern_sequencer;

  localparam int NUM_CH         = 2;
  localparam int STEPS          = 4;
  localparam int NOTE_W         = 6;
  localparam int STEP_TICKS     = 4;
  localparam int NOTE_CLK_TICKS = 3;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic restart = 1'b0;
  logic wr_en = 1'b0;
  logic [0:0] wr_ch = '0;
  logic [1:0] wr_step = '0;
  logic [NOTE_W-1:0] wr_note = '0;
  logic wr_gate = 1'b0;
  logic [NUM_CH*NOTE_W-1:0] note_out;
  logic [NUM_CH-1:0] gate_out;
  logic [1:0] step_idx;
  logic step_pulse, note_clk, beat_led;

  int errors = 0;
  int checks = 0;

  int m_mode, m_tick, m_step, m_cycles;
  logic [NOTE_W-1:0] m_note [NUM_CH];
  logic m_gate [NUM_CH];
  logic m_pulse, m_beat;
  logic [NOTE_W-1:0] pat_note [NUM_CH][STEPS];
  logic pat_gate [NUM_CH][STEPS];

  int exp_notes [5] = '{41, 46, 46, 37, 41};
  int exp_gates [5] = '{1, 1, 0, 1, 1};
  int exp_idx   [5] = '{0, 1, 2, 3, 0};
  int exp_at    [5] = '{0, 4, 8, 12, 16};

  pattern_sequencer #(
    .NUM_CH(NUM_CH), .STEPS(STEPS), .NOTE_W(NOTE_W),
    .STEP_TICKS(STEP_TICKS), .NOTE_CLK_TICKS(NOTE_CLK_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .restart(restart),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_step(wr_step), .wr_note(wr_note), .wr_gate(wr_gate),
    .note_out(note_out), .gate_out(gate_out), .step_idx(step_idx),
    .step_pulse(step_pulse), .note_clk(note_clk), .beat_led(beat_led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    m_mode = M_IDLE; m_tick = 0; m_step = 0; m_cycles = 0;
    m_pulse = 1'b0; m_beat = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_note[c] = '0; m_gate[c] = 1'b0;
      for (int s = 0; s < STEPS; s++) begin
        pat_note[c][s] = '0; pat_gate[c][s] = 1'b0;
      end
    end
  endtask

  // One clock edge of the sequencer as seen from outside: play-state rules, then the pattern write.
  task automatic modelEdge();
    int ld;
    ld = -1;
    m_cycles++;
    m_pulse = 1'b0;
    if (restart) begin
      m_mode = M_IDLE; m_tick = 0; m_step = 0;
      for (int c = 0; c < NUM_CH; c++) m_gate[c] = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (run) begin m_mode = M_PLAY; m_tick = 0; ld = 0; end
    end else if (!run) begin
      m_mode = M_PAUSE;
    end else begin
      m_mode = M_PLAY;
      m_tick = m_tick + 1;
      if (m_tick == STEP_TICKS) begin m_tick = 0; ld = (m_step + 1) % STEPS; end
    end
    if (ld >= 0) begin
      m_step = ld; m_pulse = 1'b1; m_beat = ~m_beat;
      for (int c = 0; c < NUM_CH; c++) begin
        m_gate[c] = pat_gate[c][ld];
        if (pat_gate[c][ld]) m_note[c] = pat_note[c][ld];
      end
    end
    if (wr_en && int'(wr_ch) < NUM_CH && int'(wr_step) < STEPS) begin
      pat_note[wr_ch][wr_step] = wr_note;
      pat_gate[wr_ch][wr_step] = wr_gate;
    end
  endtask

  task automatic compareAll();
    logic [NUM_CH*NOTE_W-1:0] en;
    logic [NUM_CH-1:0] eg;
    for (int c = 0; c < NUM_CH; c++) begin
      en[c*NOTE_W +: NOTE_W] = m_note[c];
      eg[c] = m_gate[c];
    end
    checkOutput("note_out", note_out, en);
    checkOutput("gate_out", gate_out, eg);
    checkOutput("step_idx", step_idx, m_step);
    checkOutput("step_pulse", step_pulse, m_pulse);
    checkOutput("note_clk", note_clk, (m_cycles / NOTE_CLK_TICKS) % 2);
    checkOutput("beat_led", beat_led, m_beat);
  endtask

  task automatic applyStimulus(input logic r, input logic rs, input logic we,
                               input int ch, input int st, input int nt, input logic g);
    run = r; restart = rs; wr_en = we;
    wr_ch = 1'(ch); wr_step = 2'(st); wr_note = 6'(nt); wr_gate = g;
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  // Reset is asserted mid-cycle so the outputs must clear without any clock edge.
  task automatic doReset();
    run = 1'b0; restart = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    checkOutput("rst_note", note_out, 0);
    checkOutput("rst_gate", gate_out, 0);
    checkOutput("rst_step", step_idx, 0);
    checkOutput("rst_pulse", step_pulse, 0);
    checkOutput("rst_nclk", note_clk, 0);
    checkOutput("rst_beat", beat_led, 0);
    resetModel();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int p, gap, k;
    bit found;
    $display("[TB] pattern_sequencer bench start");
    resetModel();
    doReset();

    applyStimulus(0, 0, 1, 0, 0, 41, 1);
    applyStimulus(0, 0, 1, 0, 1, 46, 1);
    applyStimulus(0, 0, 1, 0, 2, 44, 0);
    applyStimulus(0, 0, 1, 0, 3, 37, 1);

    p = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      if (m_pulse && p < 5) begin
        checkOutput("seq_note", note_out[NOTE_W-1:0], exp_notes[p]);
        checkOutput("seq_gate", gate_out[0], exp_gates[p]);
        checkOutput("seq_idx", step_idx, exp_idx[p]);
        checkOutput("seq_time", i, exp_at[p]);
        p++;
      end
    end
    checkOutput("seq_pulses", p, 5);

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    gap = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      gap++;
      if (step_pulse) found = 1;
    end
    checkOutput("pause_found", found, 1);
    checkOutput("pause_gap", gap, 6);

    found = 0;
    for (k = 0; k < 20 && !found; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      if (m_pulse && m_step == 2) found = 1;
    end
    checkOutput("wait_step2", found, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("restart_gate", gate_out, 0);
    checkOutput("restart_step", step_idx, 0);
    checkOutput("restart_pulse", step_pulse, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("reload_pulse", step_pulse, 1);
    checkOutput("reload_note", note_out[NOTE_W-1:0], 41);
    checkOutput("reload_gate", gate_out[0], 1);

    found = 0;
    for (k = 0; k < 20; k++) begin
      if (m_mode == M_PLAY && m_step == 0 && m_tick == STEP_TICKS - 1) begin
        found = 1;
        break;
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("wait_rbw", found, 1);
    applyStimulus(1, 0, 1, 1, 1, 13, 1);
    checkOutput("rbw_step", step_idx, 1);
    checkOutput("rbw_old_note", note_out[2*NOTE_W-1:NOTE_W], 0);
    checkOutput("rbw_old_gate", gate_out[1], 0);
    for (int i = 0; i < 4 * STEP_TICKS; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rbw_wrap_step", step_idx, 1);
    checkOutput("rbw_new_note", note_out[2*NOTE_W-1:NOTE_W], 13);
    checkOutput("rbw_new_gate", gate_out[1], 1);

    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("ram_cleared_note", note_out, 0);
    checkOutput("ram_cleared_gate", gate_out, 0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 3) == 0, int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                    $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
